// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU/MDU results into an in-order queue that drives the register file write port (optional WB_BYPASS_EN).
// Latency: accept->writeEn is 2 cycles, or 1 cycle with WB_BYPASS_EN when the queue is empty.
// Backpressure: both readies drop when the queue is full; the MDU also waits while alu_valid is high.
module regfile_wb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mdu_valid,
   input  logic [ADDR_W-1:0] mdu_addr,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   output logic              pending1,
   output logic              pending2,
   output logic [ADDR_W-1:0] writeAddr,
   output logic [DATA_W-1:0] writeData,
   output logic              writeEn
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] dat;
   } wb_ent_t;

   wb_ent_t          ent_q [DEPTH];
   wb_ent_t          ent_d [DEPTH];
   logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en_q, wr_en_d;
   wb_ent_t          port_q, port_d;

   logic    alu_fire, mdu_fire, in_keep, deq, enq, byp;
   wb_ent_t in_ent;

   // Ready looks only at the registered count, so a full queue refuses even while draining.
   always_comb begin
      alu_ready = (count_q != CNT_FULL);
      mdu_ready = alu_ready && !alu_valid;
      alu_fire  = alu_valid && alu_ready;
      mdu_fire  = mdu_valid && mdu_ready;
      in_ent.addr = alu_fire ? alu_addr : mdu_addr;
      in_ent.dat  = alu_fire ? alu_data : mdu_data;
      in_keep   = (alu_fire || mdu_fire) && (in_ent.addr != '0);
      deq       = (count_q != '0);
   end

`ifdef WB_BYPASS_EN
   assign byp = in_keep && (count_q == '0);
`else
   assign byp = 1'b0;
`endif
   assign enq = in_keep && !byp;

   always_comb begin
      ent_d     = ent_q;
      ent_vld_d = ent_vld_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      port_d    = port_q;
      wr_en_d   = 1'b0;
      if (deq) begin
         port_d              = ent_q[rd_ptr_q];
         wr_en_d             = 1'b1;
         ent_vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d            = rd_ptr_q + PTR_ONE;
      end else if (byp) begin
         port_d  = in_ent;
         wr_en_d = 1'b1;
      end
      if (enq) begin
         ent_d[wr_ptr_q]     = in_ent;
         ent_vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d            = wr_ptr_q + PTR_ONE;
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
   end

   // The entry already sitting on the write port has left the queue and is not reported.
   always_comb begin
      pending1 = 1'b0;
      pending2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld_q[i] && (ent_q[i].addr == addr1)) pending1 = 1'b1;
         if (ent_vld_q[i] && (ent_q[i].addr == addr2)) pending2 = 1'b1;
      end
      if (addr1 == '0) pending1 = 1'b0;
      if (addr2 == '0) pending2 = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         ent_vld_q <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         port_q    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         ent_vld_q <= ent_vld_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         port_q    <= port_d;
      end
   end

   assign writeEn   = wr_en_q;
   assign writeAddr = port_q.addr;
   assign writeData = port_q.dat;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: constant vector table, hand sequences, and a queue-based reference model under random traffic.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
   localparam int LAT = 1;
   localparam bit BYP = 1'b1;
`else
   localparam int LAT = 2;
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, mdu_valid, alu_ready, mdu_ready;
   logic [4:0]  alu_addr, mdu_addr, addr1, addr2, writeAddr;
   logic [31:0] alu_data, mdu_data, writeData;
   logic        pending1, pending2, writeEn;

   regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
      .addr1(addr1), .addr2(addr2), .pending1(pending1), .pending2(pending2),
      .writeAddr(writeAddr), .writeData(writeData), .writeEn(writeEn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  ma;
      logic [31:0] md;
      logic [4:0]  a1;
      logic [4:0]  a2;
   } in_t;

   typedef struct {
      in_t         i;
      logic [3:0]  comb;
      logic        wen;
      logic [4:0]  wa;
      logic [31:0] wd;
   } row_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] dat;
   } wr_t;

   int checks = 0;
   int errors = 0;

   // Reference: a queue of accepted writes plus the current write-port contents.
   wr_t         mq[$];
   wr_t         obs[$];
   logic        m_en = 1'b0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic in_t mk(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic [4:0] a1, input logic [4:0] a2);
      in_t v;
      v.rst = r; v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md; v.a1 = a1; v.a2 = a2;
      return v;
   endfunction

   function automatic row_t mkrow(input in_t v, input logic [3:0] comb, input logic wen,
                                  input logic [4:0] wa, input logic [31:0] wd);
      row_t r;
      r.i = v; r.comb = comb; r.wen = wen; r.wa = wa; r.wd = wd;
      return r;
   endfunction

   task automatic apply(input in_t v);
      rst = v.rst; alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
      mdu_valid = v.mv; mdu_addr = v.ma; mdu_data = v.md; addr1 = v.a1; addr2 = v.a2;
   endtask

   function automatic logic in_q(input logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      foreach (mq[k]) if (mq[k].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   // One model-checked cycle: entered and left at 1ns after a rising edge.
   task automatic cycle(input in_t v, output logic mdu_acc);
      logic room, acc_a, acc_m, exp_ar, exp_mr;
      wr_t  in_w, e;
      bit   bypassed;
      apply(v);
      #1;
      room   = (mq.size() < DEPTH);
      exp_ar = room;
      exp_mr = room && !v.av;
      chk("comb_outputs", {60'd0, alu_ready, mdu_ready, pending1, pending2},
          {60'd0, exp_ar, exp_mr, in_q(v.a1), in_q(v.a2)});
      acc_a   = v.av && room;
      acc_m   = v.mv && room && !v.av;
      mdu_acc = acc_m && !v.rst;
      in_w.addr = acc_a ? v.aa : v.ma;
      in_w.dat  = acc_a ? v.ad : v.md;
      @(posedge clk);
      #1;
      if (v.rst) begin
         mq.delete();
         m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         bypassed = 1'b0;
         m_en = 1'b0;
         if (mq.size() > 0) begin
            e = mq.pop_front();
            m_en = 1'b1; m_addr = e.addr; m_data = e.dat;
         end else if (BYP && (acc_a || acc_m) && in_w.addr != 5'd0) begin
            m_en = 1'b1; m_addr = in_w.addr; m_data = in_w.dat;
            bypassed = 1'b1;
         end
         if ((acc_a || acc_m) && in_w.addr != 5'd0 && !bypassed) mq.push_back(in_w);
      end
      chk("write_port", {26'd0, writeEn, writeAddr, writeData}, {26'd0, m_en, m_addr, m_data});
      if (writeEn) begin
         e.addr = writeAddr; e.dat = writeData;
         obs.push_back(e);
      end
   endtask

   initial begin
      row_t tbl[12];
      in_t  idle, cur;
      logic macc;
      int   lat;

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;

`ifndef WB_BYPASS_EN
      // comb = {alu_ready, mdu_ready, pending1, pending2}; wen/wa/wd sampled after the edge.
      tbl[0]  = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 0, 0),                        4'b1100, 0, 0, 0);
      tbl[1]  = mkrow(mk(0, 1, 14, 7, 0, 0, 0, 14, 0),                      4'b1000, 0, 0, 0);
      tbl[2]  = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 14, 3),                       4'b1110, 1, 14, 7);
      tbl[3]  = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 14, 0),                       4'b1100, 0, 14, 7);
      tbl[4]  = mkrow(mk(0, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0),             4'b1000, 0, 14, 7);
      tbl[5]  = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 0, 0),                        4'b1100, 0, 14, 7);
      tbl[6]  = mkrow(mk(0, 1, 1, 32'h10, 1, 9, 32'h99, 9, 1),              4'b1000, 0, 14, 7);
      tbl[7]  = mkrow(mk(0, 1, 2, 32'h20, 1, 9, 32'h99, 9, 1),              4'b1001, 1, 1, 32'h10);
      tbl[8]  = mkrow(mk(0, 1, 3, 32'h30, 1, 9, 32'h99, 9, 2),              4'b1001, 1, 2, 32'h20);
      tbl[9]  = mkrow(mk(0, 0, 0, 0, 1, 9, 32'h99, 9, 3),                   4'b1101, 1, 3, 32'h30);
      tbl[10] = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 9, 3),                        4'b1110, 1, 9, 32'h99);
      tbl[11] = mkrow(mk(0, 0, 0, 0, 0, 0, 0, 9, 0),                        4'b1100, 0, 9, 32'h99);
      for (int r = 0; r < 12; r++) begin
         apply(tbl[r].i);
         #1;
         chk($sformatf("tbl%0d_comb", r), {60'd0, alu_ready, mdu_ready, pending1, pending2}, {60'd0, tbl[r].comb});
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_port", r), {26'd0, writeEn, writeAddr, writeData},
             {26'd0, tbl[r].wen, tbl[r].wa, tbl[r].wd});
      end
`endif

      // Resynchronise the model with a reset cycle.
      cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), macc);

      // Reset while a write is queued: queue and port must be cleared.
      cycle(mk(0, 1, 6, 32'h66, 0, 0, 0, 6, 0), macc);
      cycle(mk(1, 0, 0, 0, 0, 0, 0, 6, 6), macc);
      chk("rst_wen", {63'd0, writeEn}, 64'd0);
      apply(mk(0, 0, 0, 0, 0, 0, 0, 6, 6));
      #1;
      chk("rst_pending", {62'd0, pending1, pending2}, 64'd0);

      // Latency of a single accepted write after reset.
      cycle(mk(0, 1, 5, 32'd1, 0, 0, 0, 0, 0), macc);
      lat = 1;
      while (!writeEn && lat < 6) begin
         cycle(idle, macc);
         lat++;
      end
      chk("latency", 64'(lat), 64'(LAT));
      chk("lat_port", {27'd0, writeAddr, writeData}, {27'd0, 5'd5, 32'd1});

      // Ten back-to-back writes wrap the pointers; order must survive.
      obs.delete();
      for (int k = 1; k <= 10; k++) cycle(mk(0, 1, 5'(k), 32'(k * 32'h11), 0, 0, 0, 5'(k), 0), macc);
      repeat (3) cycle(idle, macc);
      chk("wrap_count", 64'(obs.size()), 64'd10);
      for (int k = 0; k < 10 && k < obs.size(); k++)
         chk($sformatf("wrap_%0d", k), {27'd0, obs[k].addr, obs[k].dat}, {27'd0, 5'(k + 1), 32'((k + 1) * 32'h11)});

      // Random traffic; the MDU holds its request until accepted.
      cur = idle;
      macc = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         in_t v;
         v = cur;
         v.rst = ($urandom_range(0, 199) == 0);
         v.av  = ($urandom_range(0, 1) == 1);
         v.aa  = 5'($urandom_range(0, 7));
         v.ad  = $urandom;
         if (!cur.mv || macc || cur.rst) begin
            v.mv = ($urandom_range(0, 4) < 2);
            v.ma = 5'($urandom_range(0, 7));
            v.md = $urandom;
         end
         v.a1 = 5'($urandom_range(0, 7));
         v.a2 = 5'($urandom_range(0, 7));
         cur = v;
         cycle(v, macc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
